kronos_wbu: RTL and testbench

//  Write-back unit and pending-write scoreboard. Accepts writeback-bound instructions
//  (ALU results and loads) and tracks every destination register with an outstanding

---
 rtl/kronos_wbu.sv | 145 ++++++++++++++
 tb/tb_kronos_wbu.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_wbu.sv
// Write-back unit: pending-write scoreboard, in-order load queue and a single
// register-file write port shared between load responses and ALU results.
module kronos_wbu #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        issue_vld,
  output logic        issue_rdy,
  input  logic [4:0]  issue_rd,
  input  logic        issue_load,
  input  logic [31:0] issue_data,
  input  logic        ld_ack,
  input  logic [31:0] ld_data,
  output logic        regwr_en,
  output logic [4:0]  regwr_sel,
  output logic [31:0] regwr_data,
  output logic        regwr_pending,
  output logic [31:0] pend_mask,
  output logic        lq_full,
  output logic        ld_spurious
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    lqRd_q [LQ_DEPTH];
  logic          lqSup_q [LQ_DEPTH];

  logic          skidVld_q, skidVld_d;
  logic [4:0]    skidRd_q, skidRd_d;
  logic [31:0]   skidData_q, skidData_d;

  logic          wrEn_q, wrEn_d;
  logic [4:0]    wrSel_q, wrSel_d;
  logic [31:0]   wrData_q, wrData_d;
  logic [31:0]   pend_q, pend_d;
  logic          spurious_q;

  logic          lqEmpty, rdBusy, accept, pushLd, aluWr, ackValid;
  logic [4:0]    headRd;
  logic          headSup;
  logic [31:0]   pendSet, pendClr;

  assign lqEmpty  = (cnt_q == '0);
  assign lq_full  = (cnt_q == CW'(LQ_DEPTH));
  assign headRd   = lqRd_q[rptr_q];
  assign headSup  = lqSup_q[rptr_q];

  // A write to a register that is still pending would reorder writes (WAW), so stall it.
  assign rdBusy    = (issue_rd != 5'd0) & pend_q[issue_rd];
  assign issue_rdy = ~rst & ~rdBusy & (issue_load ? ~lq_full : ~skidVld_q);
  assign accept    = issue_vld & issue_rdy & ~flush;
  assign pushLd    = accept & issue_load;
  assign aluWr     = accept & ~issue_load & (issue_rd != 5'd0);
  assign ackValid  = ld_ack & ~lqEmpty;

  assign pendSet = (accept && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
  assign pendClr = wrEn_q ? (32'd1 << wrSel_q) : 32'd0;

  // Arbiter: load response beats skid entry, which beats a fresh ALU result.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q + CW'(pushLd) - CW'(ackValid);
    skidVld_d  = skidVld_q;
    skidRd_d   = skidRd_q;
    skidData_d = skidData_q;
    wrEn_d     = 1'b0;
    wrSel_d    = wrSel_q;
    wrData_d   = wrData_q;
    pend_d     = (pend_q & ~pendClr) | pendSet;
    if (pushLd) wptr_d = wptr_q + 1'b1;
    if (ackValid) rptr_d = rptr_q + 1'b1;
    if (ackValid) begin
      if (!headSup) begin
        wrEn_d   = 1'b1;
        wrSel_d  = headRd;
        wrData_d = ld_data;
      end
      if (aluWr) begin
        skidVld_d  = 1'b1;
        skidRd_d   = issue_rd;
        skidData_d = issue_data;
      end
    end else if (skidVld_q) begin
      wrEn_d    = 1'b1;
      wrSel_d   = skidRd_q;
      wrData_d  = skidData_q;
      skidVld_d = 1'b0;
    end else if (aluWr) begin
      wrEn_d   = 1'b1;
      wrSel_d  = issue_rd;
      wrData_d = issue_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      skidVld_q  <= 1'b0;
      skidRd_q   <= '0;
      skidData_q <= '0;
      wrEn_q     <= 1'b0;
      wrSel_q    <= '0;
      wrData_q   <= '0;
      pend_q     <= '0;
      spurious_q <= 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lqRd_q[i]  <= '0;
        lqSup_q[i] <= 1'b0;
      end
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      skidVld_q  <= skidVld_d;
      skidRd_q   <= skidRd_d;
      skidData_q <= skidData_d;
      wrEn_q     <= wrEn_d;
      wrSel_q    <= wrSel_d;
      wrData_q   <= wrData_d;
      pend_q     <= pend_d;
      spurious_q <= ld_ack & lqEmpty;
      // rd==0 loads still occupy a slot so their response is consumed silently.
      if (pushLd) begin
        lqRd_q[wptr_q]  <= issue_rd;
        lqSup_q[wptr_q] <= (issue_rd == 5'd0);
      end
    end
  end

  assign regwr_en      = wrEn_q;
  assign regwr_sel     = wrSel_q;
  assign regwr_data    = wrData_q;
  assign pend_mask     = pend_q;
  assign regwr_pending = |pend_q;
  assign ld_spurious   = spurious_q;

endmodule

// File: tb/tb_kronos_wbu.sv
// Self-checking bench for kronos_wbu: expected register writes go into a scoreboard
// queue as stimulus is driven and are popped whenever the unit strobes regwr_en.
module tb_kronos_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        issue_vld = 1'b0;
  logic        issue_rdy;
  logic [4:0]  issue_rd = '0;
  logic        issue_load = 1'b0;
  logic [31:0] issue_data = '0;
  logic        ld_ack = 1'b0;
  logic [31:0] ld_data = '0;
  logic        regwr_en;
  logic [4:0]  regwr_sel;
  logic [31:0] regwr_data;
  logic        regwr_pending;
  logic [31:0] pend_mask;
  logic        lq_full;
  logic        ld_spurious;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;

  kronos_wbu #(.LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_rd(issue_rd),
    .issue_load(issue_load), .issue_data(issue_data),
    .ld_ack(ld_ack), .ld_data(ld_data),
    .regwr_en(regwr_en), .regwr_sel(regwr_sel), .regwr_data(regwr_data),
    .regwr_pending(regwr_pending), .pend_mask(pend_mask),
    .lq_full(lq_full), .ld_spurious(ld_spurious)
  );

  always #5 clk = ~clk;

  // Every register write the unit produces must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && regwr_en) begin
      wr_t exp;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected_write got sel=%0d data=%h expected no write", regwr_sel, regwr_data);
      end else begin
        exp = sb.pop_front();
        if (regwr_sel !== exp.sel || regwr_data !== exp.data) begin
          failures++;
          $display("[TB] FAIL sb_write got sel=%0d data=%h expected sel=%0d data=%h",
                   regwr_sel, regwr_data, exp.sel, exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_vld  = 1'b0;
    issue_load = 1'b0;
    issue_rd   = '0;
    issue_data = '0;
    ld_ack     = 1'b0;
    ld_data    = '0;
    flush      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    checks++;
    if ({regwr_en, regwr_sel, regwr_data, regwr_pending, pend_mask, lq_full, ld_spurious, issue_rdy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got en=%b sel=%0d data=%h pend=%h full=%b spur=%b rdy=%b expected all 0",
               regwr_en, regwr_sel, regwr_data, pend_mask, lq_full, ld_spurious, issue_rdy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    issue_vld = 1'b1; issue_rd = 5'd5; issue_data = 32'hDEADBEEF;
    checks++;
    if (issue_rdy !== 1'b1) begin failures++; $display("[TB] FAIL alu_rdy got %b expected 1", issue_rdy); end
    sb.push_back('{sel: 5'd5, data: 32'hDEADBEEF});
    tick();
    idle();
    checks++;
    if (regwr_en !== 1'b1 || regwr_sel !== 5'd5 || pend_mask !== (32'd1 << 5)) begin
      failures++;
      $display("[TB] FAIL alu_n1 got en=%b sel=%0d pend=%h expected en=1 sel=5 pend=%h", regwr_en, regwr_sel, pend_mask, 32'd1 << 5);
    end
    tick();
    checks++;
    if (regwr_en !== 1'b0 || pend_mask !== 32'd0 || regwr_pending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL alu_n2 got en=%b pend=%h expected en=0 pend=0", regwr_en, pend_mask);
    end
  endtask

  task automatic test_load();
    issue_vld = 1'b1; issue_load = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    checks++;
    if (pend_mask !== (32'd1 << 7) || regwr_pending !== 1'b1 || lq_full !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_n1 got pend=%h pending=%b full=%b expected pend=%h pending=1 full=0", pend_mask, regwr_pending, lq_full, 32'd1 << 7);
    end
    tick();
    tick();
    ld_ack = 1'b1; ld_data = 32'h1234;
    sb.push_back('{sel: 5'd7, data: 32'h1234});
    checks++;
    if (regwr_en !== 1'b0 || pend_mask !== (32'd1 << 7)) begin
      failures++;
      $display("[TB] FAIL load_n3 got en=%b pend=%h expected en=0 pend=%h", regwr_en, pend_mask, 32'd1 << 7);
    end
    tick();
    idle();
    checks++;
    if (regwr_en !== 1'b1 || regwr_sel !== 5'd7 || regwr_data !== 32'h1234 || pend_mask !== (32'd1 << 7)) begin
      failures++;
      $display("[TB] FAIL load_n4 got en=%b sel=%0d data=%h pend=%h expected en=1 sel=7 data=1234 pend=%h",
               regwr_en, regwr_sel, regwr_data, pend_mask, 32'd1 << 7);
    end
    tick();
    checks++;
    if (pend_mask !== 32'd0) begin failures++; $display("[TB] FAIL load_n5 got pend=%h expected 0", pend_mask); end
  endtask

  task automatic test_arbitration();
    issue_vld = 1'b1; issue_load = 1'b1; issue_rd = 5'd9;
    tick();
    issue_load = 1'b0; issue_rd = 5'd3; issue_data = 32'h33;
    ld_ack = 1'b1; ld_data = 32'h99;
    sb.push_back('{sel: 5'd9, data: 32'h99});
    sb.push_back('{sel: 5'd3, data: 32'h33});
    tick();
    idle();
    issue_rd = 5'd10;
    checks++;
    if (issue_rdy !== 1'b0 || regwr_en !== 1'b1 || regwr_sel !== 5'd9 || pend_mask !== ((32'd1 << 9) | (32'd1 << 3))) begin
      failures++;
      $display("[TB] FAIL arb_n1 got rdy=%b en=%b sel=%0d pend=%h expected rdy=0 en=1 sel=9 pend=%h",
               issue_rdy, regwr_en, regwr_sel, pend_mask, (32'd1 << 9) | (32'd1 << 3));
    end
    tick();
    checks++;
    if (issue_rdy !== 1'b1 || regwr_en !== 1'b1 || regwr_sel !== 5'd3 || pend_mask !== (32'd1 << 3)) begin
      failures++;
      $display("[TB] FAIL arb_n2 got rdy=%b en=%b sel=%0d pend=%h expected rdy=1 en=1 sel=3 pend=%h",
               issue_rdy, regwr_en, regwr_sel, pend_mask, 32'd1 << 3);
    end
    idle();
    tick();
    checks++;
    if (pend_mask !== 32'd0 || regwr_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arb_n3 got en=%b pend=%h expected en=0 pend=0", regwr_en, pend_mask);
    end
  endtask

  task automatic test_full();
    issue_vld = 1'b1; issue_load = 1'b1; issue_rd = 5'd1;
    tick();
    issue_rd = 5'd2;
    tick();
    issue_rd = 5'd6;
    checks++;
    if (lq_full !== 1'b1 || issue_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_stall got full=%b rdy=%b expected full=1 rdy=0", lq_full, issue_rdy);
    end
    tick();
    checks++;
    if (lq_full !== 1'b1 || pend_mask !== ((32'd1 << 1) | (32'd1 << 2))) begin
      failures++;
      $display("[TB] FAIL full_hold got full=%b pend=%h expected full=1 pend=%h", lq_full, pend_mask, (32'd1 << 1) | (32'd1 << 2));
    end
    issue_vld = 1'b0;
    ld_ack = 1'b1; ld_data = 32'hA1;
    sb.push_back('{sel: 5'd1, data: 32'hA1});
    tick();
    issue_vld = 1'b1;
    ld_data = 32'hA2;
    checks++;
    if (issue_rdy !== 1'b1 || lq_full !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_pushpop_rdy got rdy=%b full=%b expected rdy=1 full=0", issue_rdy, lq_full);
    end
    sb.push_back('{sel: 5'd2, data: 32'hA2});
    tick();
    idle();
    checks++;
    if (lq_full !== 1'b0 || pend_mask !== ((32'd1 << 2) | (32'd1 << 6))) begin
      failures++;
      $display("[TB] FAIL full_after got full=%b pend=%h expected full=0 pend=%h", lq_full, pend_mask, (32'd1 << 2) | (32'd1 << 6));
    end
    ld_ack = 1'b1; ld_data = 32'hA6;
    sb.push_back('{sel: 5'd6, data: 32'hA6});
    tick();
    idle();
    tick();
    checks++;
    if (pend_mask !== 32'd0 || ld_spurious !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_drain got pend=%h spur=%b expected pend=0 spur=0", pend_mask, ld_spurious);
    end
  endtask

  task automatic test_rd0_spurious();
    issue_vld = 1'b1; issue_load = 1'b1; issue_rd = 5'd0;
    tick();
    idle();
    checks++;
    if (pend_mask !== 32'd0) begin failures++; $display("[TB] FAIL rd0_pend got %h expected 0", pend_mask); end
    ld_ack = 1'b1; ld_data = 32'h55;
    tick();
    checks++;
    if (regwr_en !== 1'b0 || ld_spurious !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rd0_ack got en=%b spur=%b expected en=0 spur=0", regwr_en, ld_spurious);
    end
    ld_data = 32'h66;
    tick();
    idle();
    checks++;
    if (ld_spurious !== 1'b1 || regwr_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL spurious_pulse got spur=%b en=%b expected spur=1 en=0", ld_spurious, regwr_en);
    end
    tick();
    checks++;
    if (ld_spurious !== 1'b0) begin failures++; $display("[TB] FAIL spurious_width got %b expected 0", ld_spurious); end
  endtask

  task automatic test_waw_flush_reset();
    issue_vld = 1'b1; issue_rd = 5'd4; issue_data = 32'h44;
    sb.push_back('{sel: 5'd4, data: 32'h44});
    tick();
    issue_data = 32'h45;
    checks++;
    if (issue_rdy !== 1'b0) begin failures++; $display("[TB] FAIL waw_stall got rdy=%b expected 0", issue_rdy); end
    tick();
    checks++;
    if (issue_rdy !== 1'b1) begin failures++; $display("[TB] FAIL waw_release got rdy=%b expected 1", issue_rdy); end
    sb.push_back('{sel: 5'd4, data: 32'h45});
    tick();
    idle();
    checks++;
    if (regwr_en !== 1'b1 || regwr_data !== 32'h45) begin
      failures++;
      $display("[TB] FAIL waw_write got en=%b data=%h expected en=1 data=45", regwr_en, regwr_data);
    end
    tick();
    flush = 1'b1; issue_vld = 1'b1; issue_rd = 5'd8; issue_data = 32'h88;
    tick();
    idle();
    checks++;
    if (pend_mask !== 32'd0 || regwr_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_block got pend=%h en=%b expected pend=0 en=0", pend_mask, regwr_en);
    end
    tick();
    issue_vld = 1'b1; issue_load = 1'b1; issue_rd = 5'd11;
    tick();
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if ({regwr_en, regwr_sel, regwr_data, pend_mask, regwr_pending, lq_full, ld_spurious} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset got en=%b sel=%0d data=%h pend=%h full=%b spur=%b expected all 0",
               regwr_en, regwr_sel, regwr_data, pend_mask, lq_full, ld_spurious);
    end
    tick();
    rst = 1'b0;
    tick();
    ld_ack = 1'b1; ld_data = 32'h77;
    tick();
    idle();
    checks++;
    if (ld_spurious !== 1'b1 || regwr_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_queue got spur=%b en=%b expected spur=1 en=0", ld_spurious, regwr_en);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_arbitration();
    test_full();
    test_rd0_spurious();
    test_waw_flush_reset();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_drain got %0d outstanding writes expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
